sa3d_out_quant_packer: RTL and testbench
========================================

# sa3d_out_quant_packer

Downstream stage of the 3D systolic array. It takes the per-lane 32-bit accumulator beats and requantizes each lane to int8 using per-channel scale/bias with rounding shift, zero point and saturation. It packs 8 lanes into one 64-bit AXI-stream beat for the S2MM/MM2S DMA and asserts tlast on the final beat of the output matrix. Per-channel parameters are loaded from a 64-bit parameter stream at the start of each layer.

## Interface
- LANES, 8, accumulator lanes per beat (output beat = LANES×8 bits = 64)
- ACC_W, 32, signed accumulator width per lane
- CH_DEPTH, 256, parameter RAM entries (max output channels)

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse, starts a layer; ignored unless IDLE
- cfg_out_channels  in  16  output channels; must be a multiple of LANES and ≤ CH_DEPTH
- cfg_out_rows  in  32  output pixels (matrix rows)
- cfg_shift  in  5  arithmetic right shift
- cfg_zero  in  8  signed output zero point
- param_tvalid/param_tready  in/out  1  parameter stream handshake
- param_tdata  in  64  4 channels per beat; channel k at [16k+15:16k], [15:8] = unsigned scale, [7:0] = signed bias
- s_acc_tvalid/s_acc_tready  in/out  1  accumulator stream handshake
- s_acc_tdata  in  LANES×ACC_W  lane i at [32i+31:32i]
- m_axis_tvalid/m_axis_tready  out/in  1  output handshake
- m_axis_tdata  out  64  lane i int8 at [8i+7:8i]
- m_axis_tkeep  out  8  constant 8'hFF
- m_axis_tlast  out  1  final beat of the layer
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at layer end

## Operation
- States:
  - IDLE: on start, latch all cfg_*.
    - Channels or rows = 0: go to DONE.
    - Otherwise: go to LOAD.
  - LOAD: param_tready=1. Accept cfg_out_channels/4 beats and write entries 4b..4b+3. Go to RUN after the last beat.
  - RUN: stream data. Go to DONE when the tlast beat handshakes.
  - DONE: done=1 for one cycle, then IDLE.
- Input order: pixel-major, then channel groups g = 0..G−1 with G = cfg_out_channels/LANES. Lane i of group g is channel g·LANES+i.
- Group counter wraps at G−1 and increments the row counter. The input stops being accepted after rows×G beats.
- Per lane:
  - prod = acc × scale: signed × zero-extended, 41 bits.
  - r = (prod + (shift>0 ? 1<<(shift−1) : 0)) >>> shift.
  - v = r + sext(bias) + sext(zero), computed in 42 bits.
  - Saturate v to [−128, 127].
- tlast: asserted on output beat number rows×G−1, counting from 0.

## Timing
- Reset: state = IDLE; all counters 0; every output 0, except m_axis_tkeep = 8'hFF.
- Pipeline stages:
  - S1: multiply, including the parameter RAM read indexed by group.
  - S2: round and shift.
  - S3: add, saturate, output register.
- Latency: input handshake at cycle t gives m_axis_tvalid at t+3 when there is no backpressure.
- Stall rule: the whole pipeline advances when the output register is empty or m_axis_tready=1. s_acc_tready = RUN ∧ advance ∧ beats remaining.
- Throughput: one beat per cycle under continuous valid/ready.
- m_axis_tdata and m_axis_tlast hold stable while tvalid=1 and tready=0.
- The tlast beat handshake at cycle t gives DONE at t+1, done=1 at t+1, and IDLE at t+2.
- A new start is accepted the cycle after IDLE is re-entered.
- start outside IDLE is ignored. param_tvalid outside LOAD is ignored, with tready=0.
- rst mid-operation: the pipeline flushes and in-flight beats are discarded. The parameter RAM contents are not cleared but are reloaded by the next LOAD.

## Configuration
- SA3D_OUTQ_RELU_EN:
  - Defined: after the bias add and before the zero-point add, negative values clamp to 0 (fused ReLU). Outputs are therefore in [zero, 127].
  - Undefined: no clamp, and the formula above applies unchanged.

## Test plan
- Basic requant:
  - Setup: channels=8, rows=2, shift=4, zero=0, all scale=16, bias=0.
  - Stimulus: lanes acc = 100, −1000, 5000, 0, …
  - Required output bytes: 100, −128, 127, 0. tlast on beat 1 only, then done pulse.
- Rounding:
  - Setup: scale=1, shift=1.
  - Stimulus: acc = 3, −3, 1, −1.
  - Required output: 2, −1, 1, 0.
- Bias/zero:
  - Setup: shift=0, scale=1, channel 5 bias=−10, zero=3.
  - Stimulus: acc=20 on all lanes.
  - Required output: lane 5 = 13, others = 23.
  - With SA3D_OUTQ_RELU_EN: acc=−50 gives 3.
- Backpressure:
  - Stimulus: m_axis_tready toggled in a 1010 pattern for 64 beats, with channels=16 (G=2).
  - Required: no lost or duplicated beats, tdata stable while stalled, group parameters alternate correctly.
- Boundaries:
  - start with rows=0: done pulse with no param_tready or output.
  - start during RUN: ignored.
  - rst asserted mid-RUN: all outputs 0 next cycle, then a fresh layer completes correctly.

Source files
------------

// File: rtl/sa3d_out_quant_packer.sv
// sa3d_out_quant_packer
// Requantizes LANES x 32-bit accumulator beats to int8 using per-channel
// scale/bias, a rounding arithmetic shift, a zero point and saturation. Each
// group of LANES bytes is packed into one 64-bit AXI-stream beat, and tlast
// marks the final beat of the layer. Per-channel parameters arrive on a 64-bit
// stream at the start of each layer.
// Optional feature macro: SA3D_OUTQ_RELU_EN (fused ReLU between bias add and
// zero-point add).
module sa3d_out_quant_packer #(
   parameter int LANES    = 8,
   parameter int ACC_W    = 32,
   parameter int CH_DEPTH = 256
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [15:0]            cfg_out_channels,
   input  logic [31:0]            cfg_out_rows,
   input  logic [4:0]             cfg_shift,
   input  logic [7:0]             cfg_zero,
   input  logic                   param_tvalid,
   output logic                   param_tready,
   input  logic [63:0]            param_tdata,
   input  logic                   s_acc_tvalid,
   output logic                   s_acc_tready,
   input  logic [LANES*ACC_W-1:0] s_acc_tdata,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic [LANES*8-1:0]     m_axis_tdata,
   output logic [LANES-1:0]       m_axis_tkeep,
   output logic                   m_axis_tlast,
   output logic                   busy,
   output logic                   done
);

   localparam int PROD_W  = ACC_W + 9;    // signed acc x zero-extended 8-bit scale
   localparam int EXT_W   = ACC_W + 10;   // headroom for rounding and adds
   localparam int CH_AW   = $clog2(CH_DEPTH);
   localparam int LANE_AW = $clog2(LANES);

   localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'(127);
   localparam logic signed [EXT_W-1:0] SAT_MIN = -EXT_W'(128);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t        state_r;
   logic [31:0]   rows_r;
   logic [4:0]    shift_r;
   logic [7:0]    zero_r;
   logic [15:0]   grp_last_r;
   logic [15:0]   ld_last_r;
   logic [15:0]   ld_cnt_r;
   logic [15:0]   in_grp_r;
   logic [31:0]   in_row_r;
   logic          busy_r;
   logic          done_r;

   // Parameter RAM: {scale[15:8], bias[7:0]} per channel; not cleared by reset
   logic [15:0]   param_mem_r [CH_DEPTH];

   logic                           s1_valid_r, s1_last_r;
   logic [LANES-1:0][PROD_W-1:0]   s1_prod_r;
   logic [LANES-1:0][7:0]          s1_bias_r;
   logic                           s2_valid_r, s2_last_r;
   logic [LANES-1:0][EXT_W-1:0]    s2_rq_r;
   logic [LANES-1:0][7:0]          s2_bias_r;
   logic                           m_valid_r, m_last_r;
   logic [LANES*8-1:0]             m_data_r;

   logic                           param_hs_s, advance_s, beats_left_s;
   logic                           acc_rdy_s, acc_hs_s, in_last_s, out_hs_s;
   logic [LANES-1:0][PROD_W-1:0]   s1_prod_s;
   logic [LANES-1:0][7:0]          s1_bias_s;
   logic [LANES-1:0][EXT_W-1:0]    s2_rq_s;
   logic [LANES*8-1:0]             s3_data_s;

   // Clamp a wide signed value into the int8 range
   function automatic logic [7:0] sat8(input logic signed [EXT_W-1:0] v);
      logic [7:0] res;
      if (v > SAT_MAX) begin
         res = 8'h7F;
      end else if (v < SAT_MIN) begin
         res = 8'h80;
      end else begin
         res = v[7:0];
      end
      return res;
   endfunction

   assign param_hs_s   = (state_r == ST_LOAD) && param_tvalid;
   assign advance_s    = !m_valid_r || m_axis_tready;
   assign beats_left_s = (in_row_r != rows_r);
   assign acc_rdy_s    = (state_r == ST_RUN) && advance_s && beats_left_s;
   assign acc_hs_s     = acc_rdy_s && s_acc_tvalid;
   assign in_last_s    = (in_row_r == (rows_r - 32'd1)) && (in_grp_r == grp_last_r);
   assign out_hs_s     = m_valid_r && m_axis_tready;

   // Layer control FSM: config latch, parameter load, input counting, done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         rows_r     <= 32'd0;
         shift_r    <= 5'd0;
         zero_r     <= 8'd0;
         grp_last_r <= 16'd0;
         ld_last_r  <= 16'd0;
         ld_cnt_r   <= 16'd0;
         in_grp_r   <= 16'd0;
         in_row_r   <= 32'd0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  rows_r     <= cfg_out_rows;
                  shift_r    <= cfg_shift;
                  zero_r     <= cfg_zero;
                  grp_last_r <= (cfg_out_channels >> LANE_AW) - 16'd1;
                  ld_last_r  <= (cfg_out_channels >> 2) - 16'd1;
                  ld_cnt_r   <= 16'd0;
                  in_grp_r   <= 16'd0;
                  in_row_r   <= 32'd0;
                  busy_r     <= 1'b1;
                  if ((cfg_out_channels == 16'd0) || (cfg_out_rows == 32'd0)) begin
                     state_r <= ST_DONE;
                     done_r  <= 1'b1;
                  end else begin
                     state_r <= ST_LOAD;
                  end
               end
            end
            ST_LOAD: begin
               if (param_hs_s) begin
                  if (ld_cnt_r == ld_last_r) begin
                     state_r <= ST_RUN;
                  end else begin
                     ld_cnt_r <= ld_cnt_r + 16'd1;
                  end
               end
            end
            ST_RUN: begin
               if (acc_hs_s) begin
                  if (in_grp_r == grp_last_r) begin
                     in_grp_r <= 16'd0;
                     in_row_r <= in_row_r + 32'd1;
                  end else begin
                     in_grp_r <= in_grp_r + 16'd1;
                  end
               end
               if (out_hs_s && m_last_r) begin
                  state_r <= ST_DONE;
                  done_r  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
            default: begin
               state_r <= ST_IDLE;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   // Parameter RAM write: four channels per accepted parameter beat
   always_ff @(posedge clk) begin
      if (!rst && param_hs_s) begin
         for (int k = 0; k < 4; k++) begin
            param_mem_r[{ld_cnt_r[CH_AW-3:0], 2'(k)}] <= param_tdata[16*k +: 16];
         end
      end
   end

   // S1 combinational: fetch the group's parameters and multiply by scale
   always_comb begin
      logic [CH_AW-1:0]         idx;
      logic [15:0]              ent;
      logic signed [PROD_W-1:0] a_x;
      logic signed [PROD_W-1:0] s_x;
      s1_prod_s = '0;
      s1_bias_s = '0;
      for (int i = 0; i < LANES; i++) begin
         idx = CH_AW'({in_grp_r, LANE_AW'(i)});
         ent = param_mem_r[idx];
         a_x = PROD_W'($signed(s_acc_tdata[ACC_W*i +: ACC_W]));
         s_x = PROD_W'({1'b0, ent[15:8]});
         s1_prod_s[i] = a_x * s_x;
         s1_bias_s[i] = ent[7:0];
      end
   end

   // S2 combinational: round-half-up and arithmetic right shift
   always_comb begin
      logic signed [EXT_W-1:0] rnd;
      logic signed [EXT_W-1:0] sum;
      s2_rq_s = '0;
      if (shift_r != 5'd0) begin
         rnd = EXT_W'(1) << (shift_r - 5'd1);
      end else begin
         rnd = '0;
      end
      for (int i = 0; i < LANES; i++) begin
         sum = EXT_W'($signed(s1_prod_r[i])) + rnd;
         s2_rq_s[i] = sum >>> shift_r;
      end
   end

   // S3 combinational: bias add, optional ReLU, zero-point add, saturate
   always_comb begin
      logic signed [EXT_W-1:0] pre;
      logic signed [EXT_W-1:0] v;
      s3_data_s = '0;
      for (int i = 0; i < LANES; i++) begin
         pre = $signed(s2_rq_r[i]) + EXT_W'($signed(s2_bias_r[i]));
`ifdef SA3D_OUTQ_RELU_EN
         if (pre < 0) begin
            pre = '0;
         end else begin
            pre = pre;
         end
`endif
         v = pre + EXT_W'($signed(zero_r));
         s3_data_s[8*i +: 8] = sat8(v);
      end
   end

   // Three-stage datapath; all stages advance together when the output can move
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r <= 1'b0;
         s1_last_r  <= 1'b0;
         s1_prod_r  <= '0;
         s1_bias_r  <= '0;
         s2_valid_r <= 1'b0;
         s2_last_r  <= 1'b0;
         s2_rq_r    <= '0;
         s2_bias_r  <= '0;
         m_valid_r  <= 1'b0;
         m_last_r   <= 1'b0;
         m_data_r   <= '0;
      end else if (advance_s) begin
         s1_valid_r <= acc_hs_s;
         s1_last_r  <= acc_hs_s && in_last_s;
         s1_prod_r  <= s1_prod_s;
         s1_bias_r  <= s1_bias_s;
         s2_valid_r <= s1_valid_r;
         s2_last_r  <= s1_last_r;
         s2_rq_r    <= s2_rq_s;
         s2_bias_r  <= s1_bias_r;
         m_valid_r  <= s2_valid_r;
         m_last_r   <= s2_valid_r && s2_last_r;
         if (s2_valid_r) begin
            m_data_r <= s3_data_s;
         end
      end
   end

   assign param_tready  = (state_r == ST_LOAD);
   assign s_acc_tready  = acc_rdy_s;
   assign m_axis_tvalid = m_valid_r;
   assign m_axis_tdata  = m_data_r;
   assign m_axis_tlast  = m_last_r;
   assign m_axis_tkeep  = {LANES{1'b1}};
   assign busy          = busy_r;
   assign done          = done_r;

endmodule

// File: tb/tb_sa3d_out_quant_packer.sv
// Directed self-checking bench for sa3d_out_quant_packer.
module tb_sa3d_out_quant_packer;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [15:0]   cfg_out_channels;
   logic [31:0]   cfg_out_rows;
   logic [4:0]    cfg_shift;
   logic [7:0]    cfg_zero;
   logic          param_tvalid;
   logic          param_tready;
   logic [63:0]   param_tdata;
   logic          s_acc_tvalid;
   logic          s_acc_tready;
   logic [255:0]  s_acc_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic [63:0]   m_axis_tdata;
   logic [7:0]    m_axis_tkeep;
   logic          m_axis_tlast;
   logic          busy;
   logic          done;

   sa3d_out_quant_packer dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_out_channels(cfg_out_channels), .cfg_out_rows(cfg_out_rows),
      .cfg_shift(cfg_shift), .cfg_zero(cfg_zero),
      .param_tvalid(param_tvalid), .param_tready(param_tready), .param_tdata(param_tdata),
      .s_acc_tvalid(s_acc_tvalid), .s_acc_tready(s_acc_tready), .s_acc_tdata(s_acc_tdata),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt = 0;
   int ptr_seen = 0;
   int tv_seen = 0;

   logic [15:0]  pmem [256];
   logic [255:0] acc_q [$];
   logic [63:0]  out_d [$];
   bit           out_l [$];
   int           first_in_cyc, first_out_cyc, stall_err;
   bit           done_after_last, busy_after_last, bp_mode;

   // Free-running cycle counter
   always @(posedge clk) cyc <= cyc + 1;

   // Event monitors sampled mid-cycle
   always @(negedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
      if (param_tready) ptr_seen <= ptr_seen + 1;
      if (m_axis_tvalid) tv_seen <= tv_seen + 1;
   end

   initial begin
      #3000000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   function automatic logic [255:0] mk_acc(input int v[8]);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = v[i];
      return r;
   endfunction

   // Reference requantization written directly from the arithmetic definition
   function automatic logic [7:0] ref_byte(input longint acc, input int scale, input int bias,
                                           input int sh, input int zr);
      longint p, v;
      p = acc * scale;
      if (sh > 0) p = p + (longint'(1) << (sh - 1));
      p = p >>> sh;
      v = p + bias;
`ifdef SA3D_OUTQ_RELU_EN
      if (v < 0) v = 0;
`endif
      v = v + zr;
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      return v[7:0];
   endfunction

   task automatic do_start(input int ch, input int rows, input int sh, input int zr);
      @(posedge clk); #1;
      start = 1'b1;
      cfg_out_channels = 16'(ch);
      cfg_out_rows = 32'(rows);
      cfg_shift = 5'(sh);
      cfg_zero = 8'(zr);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic load_params(input int ch);
      for (int b = 0; b < ch / 4; b++) begin
         bit hs = 1'b0;
         int n = 0;
         param_tvalid = 1'b1;
         param_tdata = {pmem[4*b+3], pmem[4*b+2], pmem[4*b+1], pmem[4*b]};
         while (!hs) begin
            @(negedge clk);
            hs = param_tready;
            @(posedge clk); #1;
            n++;
            if (!hs && n > 50) begin
               checks++; errors++;
               $display("FAIL param_load_timeout beat=%0d", b);
               param_tvalid = 1'b0;
               return;
            end
         end
      end
      param_tvalid = 1'b0;
   endtask

   task automatic drive_acc();
      first_in_cyc = -1;
      for (int b = 0; b < acc_q.size(); b++) begin
         bit hs = 1'b0;
         int n = 0;
         s_acc_tvalid = 1'b1;
         s_acc_tdata = acc_q[b];
         while (!hs) begin
            @(negedge clk);
            hs = s_acc_tready;
            if (hs && first_in_cyc < 0) first_in_cyc = cyc;
            @(posedge clk); #1;
            n++;
            if (!hs && n > 200) begin
               checks++; errors++;
               $display("FAIL acc_drive_timeout beat=%0d", b);
               s_acc_tvalid = 1'b0;
               return;
            end
         end
      end
      s_acc_tvalid = 1'b0;
   endtask

   task automatic collect(input int n);
      int c = 0;
      bit prev_st = 1'b0;
      logic [63:0] prev_d = '0;
      logic prev_l = 1'b0;
      out_d.delete();
      out_l.delete();
      first_out_cyc = -1;
      stall_err = 0;
      while (out_d.size() < n && c < 2000) begin
         m_axis_tready = bp_mode ? ((c % 2) == 0) : 1'b1;
         @(negedge clk);
         if (m_axis_tvalid) begin
            if (first_out_cyc < 0) first_out_cyc = cyc;
            if (prev_st && (m_axis_tdata !== prev_d || m_axis_tlast !== prev_l)) stall_err++;
            if (m_axis_tready) begin
               out_d.push_back(m_axis_tdata);
               out_l.push_back(m_axis_tlast);
            end
         end
         prev_st = m_axis_tvalid && !m_axis_tready;
         prev_d = m_axis_tdata;
         prev_l = m_axis_tlast;
         @(posedge clk); #1;
         c++;
      end
      if (out_d.size() < n) begin
         checks++; errors++;
         $display("FAIL collect_timeout got=%0d want=%0d", out_d.size(), n);
         while (out_d.size() < n) begin
            out_d.push_back(64'hDEAD_BEEF_DEAD_BEEF);
            out_l.push_back(1'b0);
         end
      end
      m_axis_tready = 1'b1;
      @(negedge clk);
      done_after_last = done;
      @(posedge clk); #1;
      @(negedge clk);
      busy_after_last = busy;
      @(posedge clk); #1;
   endtask

   task automatic stream(input int n, input bit bp);
      bp_mode = bp;
      fork
         drive_acc();
         collect(n);
      join
   endtask

   task automatic set_basic();
      for (int c = 0; c < 256; c++) pmem[c] = {8'd16, 8'd0};
      acc_q.delete();
      acc_q.push_back(mk_acc('{100, -1000, 5000, 0, 7, -7, 2047, -2048}));
      acc_q.push_back(mk_acc('{127, -128, 128, -129, 50, -50, 1, -1}));
   endtask

   task automatic check_basic(input string tag, input int d0);
      checks++;
      if (out_d[0] !== 64'h807F_F907_007F_8064) begin
         errors++; $display("FAIL %s_beat0 got=%h want=%h", tag, out_d[0], 64'h807F_F907_007F_8064);
      end
      checks++;
      if (out_d[1] !== 64'hFF01_CE32_807F_807F) begin
         errors++; $display("FAIL %s_beat1 got=%h want=%h", tag, out_d[1], 64'hFF01_CE32_807F_807F);
      end
      checks++;
      if (out_l[0] !== 1'b0 || out_l[1] !== 1'b1) begin
         errors++; $display("FAIL %s_tlast got=%b%b want=01", tag, out_l[0], out_l[1]);
      end
      checks++;
      if (done_after_last !== 1'b1) begin
         errors++; $display("FAIL %s_done_after_last got=%b want=1", tag, done_after_last);
      end
      checks++;
      if (busy_after_last !== 1'b0) begin
         errors++; $display("FAIL %s_idle_after_done got=%b want=0", tag, busy_after_last);
      end
      checks++;
      if (done_cnt - d0 != 1) begin
         errors++; $display("FAIL %s_done_pulses got=%0d want=1", tag, done_cnt - d0);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 64'd0 || m_axis_tlast !== 1'b0) begin
         errors++; $display("FAIL reset_out got v=%b d=%h l=%b want 0", m_axis_tvalid, m_axis_tdata, m_axis_tlast);
      end
      checks++;
      if (m_axis_tkeep !== 8'hFF) begin
         errors++; $display("FAIL reset_tkeep got=%h want=ff", m_axis_tkeep);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || param_tready !== 1'b0 || s_acc_tready !== 1'b0) begin
         errors++; $display("FAIL reset_ctrl got busy=%b done=%b ptr=%b atr=%b want 0", busy, done, param_tready, s_acc_tready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int d0;
      set_basic();
      d0 = done_cnt;
      do_start(8, 2, 4, 0);
      load_params(8);
      stream(2, 1'b0);
      check_basic("basic", d0);
      checks++;
      if (first_out_cyc - first_in_cyc != 3) begin
         errors++; $display("FAIL latency got=%0d want=3", first_out_cyc - first_in_cyc);
      end
   endtask

   task automatic test_rounding();
      for (int c = 0; c < 256; c++) pmem[c] = {8'd1, 8'd0};
      acc_q.delete();
      acc_q.push_back(mk_acc('{3, -3, 1, -1, 5, -5, 0, 2}));
      do_start(8, 1, 1, 0);
      load_params(8);
      stream(1, 1'b0);
      checks++;
      if (out_d[0] !== 64'h0100_FE03_0001_FF02 || out_l[0] !== 1'b1) begin
         errors++; $display("FAIL rounding got=%h/%b want=%h/1", out_d[0], out_l[0], 64'h0100_FE03_0001_FF02);
      end
   endtask

   task automatic test_bias_zero();
      logic [63:0] exp1;
      for (int c = 0; c < 256; c++) pmem[c] = {8'd1, 8'd0};
      pmem[5] = {8'd1, 8'hF6};
      acc_q.delete();
      acc_q.push_back(mk_acc('{20, 20, 20, 20, 20, 20, 20, 20}));
      acc_q.push_back(mk_acc('{-50, -50, -50, -50, -50, -50, -50, -50}));
`ifdef SA3D_OUTQ_RELU_EN
      exp1 = 64'h0303_0303_0303_0303;
`else
      exp1 = 64'hD1D1_C7D1_D1D1_D1D1;
`endif
      do_start(8, 2, 0, 3);
      load_params(8);
      stream(2, 1'b0);
      checks++;
      if (out_d[0] !== 64'h1717_0D17_1717_1717) begin
         errors++; $display("FAIL bias_zero_pos got=%h want=%h", out_d[0], 64'h1717_0D17_1717_1717);
      end
      checks++;
      if (out_d[1] !== exp1) begin
         errors++; $display("FAIL bias_zero_neg got=%h want=%h", out_d[1], exp1);
      end
   endtask

   task automatic test_backpressure();
      int bad = 0;
      int last_bad = 0;
      for (int c = 0; c < 16; c++) pmem[c] = {8'(c + 1), 8'(c - 8)};
      acc_q.delete();
      for (int b = 0; b < 64; b++) begin
         int v[8];
         for (int i = 0; i < 8; i++) v[i] = ((b * 97 + i * 53) % 400) - 200;
         acc_q.push_back(mk_acc(v));
      end
      do_start(16, 32, 2, -5);
      load_params(16);
      stream(64, 1'b1);
      checks++;
      if (stall_err != 0) begin
         errors++; $display("FAIL bp_stall_stable got=%0d changes want=0", stall_err);
      end
      for (int b = 0; b < 64; b++) begin
         logic [63:0] e;
         for (int i = 0; i < 8; i++) begin
            int ch = (b % 2) * 8 + i;
            e[8*i +: 8] = ref_byte(longint'(((b * 97 + i * 53) % 400) - 200), int'(pmem[ch][15:8]),
                                   int'($signed(pmem[ch][7:0])), 2, -5);
         end
         checks++;
         if (out_d[b] !== e) begin
            errors++; bad++;
            $display("FAIL bp_beat%0d got=%h want=%h", b, out_d[b], e);
         end
         if (out_l[b] !== (b == 63)) last_bad++;
      end
      checks++;
      if (last_bad != 0) begin
         errors++; $display("FAIL bp_tlast got=%0d wrong beats want=0", last_bad);
      end
   endtask

   task automatic test_rows_zero();
      int d0 = done_cnt;
      int p0 = ptr_seen;
      int t0 = tv_seen;
      do_start(8, 0, 0, 0);
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (done_cnt - d0 != 1) begin
         errors++; $display("FAIL rows0_done got=%0d want=1", done_cnt - d0);
      end
      checks++;
      if (ptr_seen != p0 || tv_seen != t0) begin
         errors++; $display("FAIL rows0_activity got ptr=%0d tv=%0d want 0", ptr_seen - p0, tv_seen - t0);
      end
   endtask

   task automatic test_start_during_run();
      int d0;
      set_basic();
      d0 = done_cnt;
      do_start(8, 2, 4, 0);
      load_params(8);
      do_start(16, 0, 0, 0);
      stream(2, 1'b0);
      check_basic("start_in_run", d0);
   endtask

   task automatic test_rst_mid_run();
      int d0;
      set_basic();
      do_start(8, 4, 4, 0);
      load_params(8);
      m_axis_tready = 1'b0;
      s_acc_tvalid = 1'b1;
      s_acc_tdata = acc_q[0];
      repeat (6) @(posedge clk);
      #1;
      @(negedge clk);
      checks++;
      if (m_axis_tvalid !== 1'b1) begin
         errors++; $display("FAIL rst_mid_prefill got=%b want=1", m_axis_tvalid);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      s_acc_tvalid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 64'd0 || m_axis_tlast !== 1'b0 ||
          busy !== 1'b0 || done !== 1'b0 || s_acc_tready !== 1'b0 || param_tready !== 1'b0) begin
         errors++; $display("FAIL rst_mid_outputs got v=%b d=%h l=%b busy=%b want 0", m_axis_tvalid, m_axis_tdata, m_axis_tlast, busy);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      m_axis_tready = 1'b1;
      @(posedge clk); #1;
      d0 = done_cnt;
      do_start(8, 2, 4, 0);
      load_params(8);
      stream(2, 1'b0);
      check_basic("after_rst", d0);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      cfg_out_channels = 16'd0;
      cfg_out_rows = 32'd0;
      cfg_shift = 5'd0;
      cfg_zero = 8'd0;
      param_tvalid = 1'b0;
      param_tdata = 64'd0;
      s_acc_tvalid = 1'b0;
      s_acc_tdata = 256'd0;
      m_axis_tready = 1'b1;
      bp_mode = 1'b0;
      test_reset();
      test_basic();
      test_rounding();
      test_bias_zero();
      test_backpressure();
      test_rows_zero();
      test_start_during_run();
      test_rst_mid_run();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
